// File: rtl/params.sv
// Shared types and constants for the operand responder and its address generator.
package params;

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP16 = 2'd1,
        INT8 = 2'd2,
        INT4 = 2'd3
    } datatype_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } rsp_state_t;

    localparam int unsigned RSP_LATENCY = 2;

    // FP16 operands live in the low half-word; the upper half is zeroed.
    function automatic logic [31:0] fmt_word(input logic [31:0] w, input datatype_t dt);
        if (dt == FP16) return {16'h0000, w[15:0]};
        return w;
    endfunction

endpackage

// File: rtl/operand_sram.sv
// Single-port operand buffer, 32-bit words, synchronous read.
module operand_sram #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/operand_rsp.sv
// Operand-buffer responder: load phase fills A/B buffers, serve phase returns
// formatted operand words two cycles after each sampled request.
module operand_rsp
    import params::*;
#(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     load_done,
    input  logic                     abort,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data,
    input  datatype_t                datatype,
    input  logic                     en_in,
    input  logic                     cmin,
    input  logic [AW-1:0]            rdaddr_A,
    input  logic [AW-1:0]            rdaddr_B,
    output logic                     vld_out,
    output logic                     cmen_out,
    output logic [31:0]              data_A,
    output logic [31:0]              data_B,
    output logic                     err_out,
    output logic [1:0]               state_out,
    output logic [15:0]              rsp_cnt
);

    localparam int unsigned IW = $clog2(DEPTH);

    rsp_state_t state_q;

    // Request stage (edge N)
    logic          s0_vld, s0_cm, s0_oor_a, s0_oor_b;
    datatype_t     s0_dt;
    logic [IW-1:0] s0_idx_a, s0_idx_b;
    // RAM stage (edge N+1)
    logic          s1_vld, s1_cm, s1_oor_a, s1_oor_b;
    datatype_t     s1_dt;

    logic [AW-2:0] idx_a, idx_b;
    logic          oor_a, oor_b, req_ok, wr_oor, wr_ok, serve_entry, err_d;
    logic [IW-1:0] addr_a, addr_b;
    logic [31:0]   ram_a, ram_b;
    logic          unused_bits;

    // Bit 0 of the request address is a sub-word selector and never indexes the buffer.
    function automatic logic [AW-2:0] word_idx(input logic [AW-2:0] half, input datatype_t dt);
        if (dt == INT4) return {1'b0, half[AW-2:1]};
        return half;
    endfunction

    assign unused_bits = ^{rdaddr_A[0], rdaddr_B[0]};

    assign idx_a       = word_idx(rdaddr_A[AW-1:1], datatype);
    assign idx_b       = word_idx(rdaddr_B[AW-1:1], datatype);
    assign oor_a       = idx_a >= (AW-1)'(DEPTH);
    assign oor_b       = idx_b >= (AW-1)'(DEPTH);
    assign req_ok      = en_in && (state_q == SERVE) && !abort;
    assign wr_oor      = {1'b0, wr_addr} >= (IW+1)'(DEPTH);
    assign wr_ok       = wr_en && (state_q == LOAD) && !abort && !wr_oor;
    assign serve_entry = !abort && (state_q == LOAD) && load_done;

    assign err_d = (wr_en && ((state_q != LOAD) || wr_oor))
                 || (en_in && (state_q != SERVE))
                 || (req_ok && (oor_a || oor_b));

    // Writes and reads occupy disjoint states, so the port is shared by state.
    assign addr_a    = (state_q == LOAD) ? wr_addr : s0_idx_a;
    assign addr_b    = (state_q == LOAD) ? wr_addr : s0_idx_b;
    assign state_out = state_q;

    operand_sram #(.DEPTH(DEPTH), .IW(IW)) u_sram_a (
        .clk   (clk),
        .we    (wr_ok && !wr_sel),
        .addr  (addr_a),
        .wdata (wr_data),
        .rdata (ram_a)
    );

    operand_sram #(.DEPTH(DEPTH), .IW(IW)) u_sram_b (
        .clk   (clk),
        .we    (wr_ok && wr_sel),
        .addr  (addr_b),
        .wdata (wr_data),
        .rdata (ram_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else if (abort) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (load_start) state_q <= LOAD;
                LOAD:    if (load_done) state_q <= SERVE;
                SERVE:   state_q <= SERVE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_vld   <= 1'b0;
            s0_cm    <= 1'b0;
            s0_oor_a <= 1'b0;
            s0_oor_b <= 1'b0;
            s0_dt    <= FP32;
            s0_idx_a <= '0;
            s0_idx_b <= '0;
            s1_vld   <= 1'b0;
            s1_cm    <= 1'b0;
            s1_oor_a <= 1'b0;
            s1_oor_b <= 1'b0;
            s1_dt    <= FP32;
            vld_out  <= 1'b0;
            cmen_out <= 1'b0;
            data_A   <= '0;
            data_B   <= '0;
            err_out  <= 1'b0;
            rsp_cnt  <= '0;
        end else begin
            err_out  <= err_d;
            s0_vld   <= req_ok;
            s0_cm    <= cmin;
            s0_oor_a <= oor_a;
            s0_oor_b <= oor_b;
            s0_dt    <= datatype;
            s0_idx_a <= idx_a[IW-1:0];
            s0_idx_b <= idx_b[IW-1:0];
            // abort kills everything in flight
            s1_vld   <= s0_vld && !abort;
            s1_cm    <= s0_cm;
            s1_oor_a <= s0_oor_a;
            s1_oor_b <= s0_oor_b;
            s1_dt    <= s0_dt;
            vld_out  <= s1_vld && !abort;
            cmen_out <= s1_vld && !abort && s1_cm;
            if (s1_vld && !abort) begin
                data_A <= s1_oor_a ? 32'h0 : fmt_word(ram_a, s1_dt);
                data_B <= s1_oor_b ? 32'h0 : fmt_word(ram_b, s1_dt);
            end
            if (serve_entry) begin
                rsp_cnt <= '0;
            end else if (s1_vld && !abort && (rsp_cnt != 16'hFFFF)) begin
                rsp_cnt <= rsp_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_operand_rsp.sv
// Directed-vector bench for operand_rsp.
module tb_operand_rsp;
    import params::*;

    logic        clk;
    logic        rst;
    logic        load_start, load_done, abort;
    logic        wr_en, wr_sel;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    datatype_t   datatype;
    logic        en_in, cmin;
    logic [31:0] rdaddr_A, rdaddr_B;
    logic        vld_out, cmen_out, err_out;
    logic [31:0] data_A, data_B;
    logic [1:0]  state_out;
    logic [15:0] rsp_cnt;

    int n_vec = 0;
    int n_err = 0;

    operand_rsp #(.DEPTH(128), .AW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_done  (load_done),
        .abort      (abort),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .datatype   (datatype),
        .en_in      (en_in),
        .cmin       (cmin),
        .rdaddr_A   (rdaddr_A),
        .rdaddr_B   (rdaddr_B),
        .vld_out    (vld_out),
        .cmen_out   (cmen_out),
        .data_A     (data_A),
        .data_B     (data_B),
        .err_out    (err_out),
        .state_out  (state_out),
        .rsp_cnt    (rsp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [6:0] addr, input logic [31:0] data,
                      input logic done);
        wr_en     = 1'b1;
        wr_sel    = sel;
        wr_addr   = addr;
        wr_data   = data;
        load_done = done;
        tick();
        wr_en     = 1'b0;
        load_done = 1'b0;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] b, input logic cm);
        en_in    = 1'b1;
        cmin     = cm;
        rdaddr_A = a;
        rdaddr_B = b;
        tick();
        en_in    = 1'b0;
        cmin     = 1'b0;
    endtask

    task automatic pulse_ctl(input logic ls, input logic ld, input logic ab);
        load_start = ls;
        load_done  = ld;
        abort      = ab;
        tick();
        load_start = 1'b0;
        load_done  = 1'b0;
        abort      = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {load_start, load_done, abort, wr_en, wr_sel, en_in, cmin} = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rdaddr_A = '0;
        rdaddr_B = '0;
        datatype = FP32;
        #3 rst = 1'b0;
        #10;
        check("rst_state", {30'h0, state_out}, 32'd0);
        check("rst_vld", {31'h0, vld_out}, 32'd0);
        check("rst_cmen", {31'h0, cmen_out}, 32'd0);
        check("rst_data_a", data_A, 32'h0);
        check("rst_data_b", data_B, 32'h0);
        check("rst_err", {31'h0, err_out}, 32'd0);
        check("rst_cnt", {16'h0, rsp_cnt}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Load phase; final write shares its edge with load_done
        pulse_ctl(1'b1, 1'b0, 1'b0);
        check("load_state", {30'h0, state_out}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            wr(1'b0, 7'(i), (i == 1) ? 32'hDEAD_BEEF : 32'h1000_0000 + i, 1'b0);
            wr(1'b1, 7'(i), 32'h2000_0000 + i, (i == 7));
        end
        check("serve_state", {30'h0, state_out}, 32'd2);
        check("serve_cnt0", {16'h0, rsp_cnt}, 32'd0);
        check("load_no_err", {31'h0, err_out}, 32'd0);

        // FP32 back-to-back, second request reads the last-loaded word
        datatype = FP32;
        req(32'd4, 32'd6, 1'b1);
        req(32'd0, 32'd14, 1'b0);
        check("fp32_lat_vld", {31'h0, vld_out}, 32'd0);
        tick();
        check("fp32_vld", {31'h0, vld_out}, 32'd1);
        check("fp32_cmen", {31'h0, cmen_out}, 32'd1);
        check("fp32_a", data_A, 32'h1000_0002);
        check("fp32_b", data_B, 32'h2000_0003);
        check("fp32_cnt1", {16'h0, rsp_cnt}, 32'd1);
        tick();
        check("b2b_vld", {31'h0, vld_out}, 32'd1);
        check("b2b_cmen", {31'h0, cmen_out}, 32'd0);
        check("b2b_a", data_A, 32'h1000_0000);
        check("b2b_b_last_wr", data_B, 32'h2000_0007);
        check("b2b_cnt2", {16'h0, rsp_cnt}, 32'd2);
        tick();
        check("b2b_vld_end", {31'h0, vld_out}, 32'd0);

        // FP16 upper half cleared
        datatype = FP16;
        req(32'd2, 32'd0, 1'b0);
        tick();
        tick();
        check("fp16_vld", {31'h0, vld_out}, 32'd1);
        check("fp16_a", data_A, 32'h0000_BEEF);
        check("fp16_b", data_B, 32'h0000_0000);

        // Out-of-range B index
        datatype = FP32;
        req(32'd0, 32'd256, 1'b0);
        check("oor_err", {31'h0, err_out}, 32'd1);
        tick();
        check("oor_err_once", {31'h0, err_out}, 32'd0);
        tick();
        check("oor_vld", {31'h0, vld_out}, 32'd1);
        check("oor_b_zero", data_B, 32'h0);
        check("oor_a", data_A, 32'h1000_0000);
        check("oor_cnt4", {16'h0, rsp_cnt}, 32'd4);

        // Write attempted during SERVE is dropped
        wr(1'b0, 7'd0, 32'hFFFF_FFFF, 1'b0);
        check("serve_wr_err", {31'h0, err_out}, 32'd1);
        tick();
        check("serve_wr_err_once", {31'h0, err_out}, 32'd0);
        check("serve_wr_no_vld", {31'h0, vld_out}, 32'd0);

        // Abort one edge after a request
        req(32'd4, 32'd6, 1'b1);
        pulse_ctl(1'b0, 1'b0, 1'b1);
        check("abort_state", {30'h0, state_out}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_vld", {31'h0, vld_out}, 32'd0);
            tick();
        end

        // Request during LOAD
        pulse_ctl(1'b1, 1'b0, 1'b0);
        req(32'd0, 32'd0, 1'b0);
        check("load_req_err", {31'h0, err_out}, 32'd1);
        tick();
        check("load_req_err_once", {31'h0, err_out}, 32'd0);
        tick();
        check("load_req_no_vld", {31'h0, vld_out}, 32'd0);
        pulse_ctl(1'b0, 1'b1, 1'b0);
        check("reserve_state", {30'h0, state_out}, 32'd2);
        check("reserve_cnt_clr", {16'h0, rsp_cnt}, 32'd0);

        // INT4 indexing, three back-to-back
        datatype = INT4;
        req(32'd4, 32'd0, 1'b0);
        req(32'd8, 32'd0, 1'b0);
        req(32'd12, 32'd0, 1'b0);
        check("int4_a1", data_A, 32'hDEAD_BEEF);
        check("int4_vld1", {31'h0, vld_out}, 32'd1);
        tick();
        check("int4_a2", data_A, 32'h1000_0002);
        check("int4_vld2", {31'h0, vld_out}, 32'd1);
        tick();
        check("int4_a3", data_A, 32'h1000_0003);
        check("int4_vld3", {31'h0, vld_out}, 32'd1);
        check("int4_cnt3", {16'h0, rsp_cnt}, 32'd3);
        tick();

        // A[0] survived the rejected SERVE write
        datatype = FP32;
        req(32'd0, 32'd0, 1'b1);
        tick();
        tick();
        check("unchanged_a0", data_A, 32'h1000_0000);
        check("pre_rst_vld", {31'h0, vld_out}, 32'd1);

        // Asynchronous reset mid-SERVE
        req(32'd2, 32'd2, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("arst_state", {30'h0, state_out}, 32'd0);
        check("arst_vld", {31'h0, vld_out}, 32'd0);
        check("arst_cmen", {31'h0, cmen_out}, 32'd0);
        check("arst_data_a", data_A, 32'h0);
        check("arst_data_b", data_B, 32'h0);
        check("arst_cnt", {16'h0, rsp_cnt}, 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_vld", {31'h0, vld_out}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/operand_rsp.md
# operand_rsp

Operand-buffer responder for the systolic tensor core. It sits between the A/B operand SRAMs and the address generator at the array edge. It accepts per-cycle read requests (enable, compute-enable tag, `rdaddr_A`, `rdaddr_B`) and returns the addressed 32-bit operand words two cycles later, formatted per datatype. It also owns the load phase that fills both buffers before compute.

## Interface
- `DEPTH`, 128: 32-bit words per operand buffer (A and B each).
- `AW`, 32: request address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `load_start` in 1: pulse; enter LOAD.
- `load_done` in 1: pulse; leave LOAD, enter SERVE.
- `abort` in 1: pulse; return to IDLE from any state.
- `wr_en` in 1: buffer write strobe (LOAD only).
- `wr_sel` in 1: 0 = A buffer, 1 = B buffer.
- `wr_addr` in $clog2(DEPTH): word index.
- `wr_data` in 32: write data.
- `datatype` in `params::datatype_t`: FP32/FP16/INT8/INT4. Must be held stable while in SERVE.
- `en_in` in 1: read request valid.
- `cmin` in 1: compute-enable tag travelling with the request.
- `rdaddr_A`, `rdaddr_B` in AW: request addresses.
- `vld_out` out 1: response valid.
- `cmen_out` out 1: delayed `cmin`.
- `data_A`, `data_B` out 32: operand words.
- `err_out` out 1: one-cycle pulse on a protocol/range error.
- `state_out` out 2: current state, for debug.
- `rsp_cnt` out 16: count of served responses since SERVE entry.

## Operation
- States: IDLE (0), LOAD (1), SERVE (2).
  - IDLE → LOAD on `load_start`.
  - LOAD → SERVE on `load_done`.
  - any → IDLE on `abort`.
  - `abort` has priority over all other inputs.
  - `load_start` is ignored in LOAD and SERVE.
  - `load_done` is ignored outside LOAD.
- Writes: accepted only in LOAD.
  - `wr_en` in any other state is dropped and pulses `err_out`.
  - `wr_addr` ≥ DEPTH is dropped and pulses `err_out`.
- Word index = `rdaddr_X[AW-1:1]` (bit 0 discarded) for FP32, FP16 and INT8. For INT4 the index is `rdaddr_X[AW-1:2]`.
- Out of range: an index ≥ DEPTH returns 0 for that operand and pulses `err_out`. The response is still marked valid.
- Requests: served only in SERVE.
  - `en_in` outside SERVE produces no response and pulses `err_out` once per offending cycle.
- Formatting on the read word:
  - FP32, INT8, INT4: passed unchanged.
  - FP16: bits [31:16] forced to 0.
- `rsp_cnt` clears on SERVE entry and increments once per `vld_out`. It saturates at 0xFFFF.
- `abort` with requests in flight: the pipeline is flushed and no further `vld_out` is produced for those requests.

## Timing
- Reset values: state IDLE, `vld_out` 0, `cmen_out` 0, `data_A`/`data_B` 0, `err_out` 0, `rsp_cnt` 0. Buffer contents are undefined after reset.
- Read latency is 2 cycles. A request sampled at edge N:
  - RAM read at edge N+1.
  - Format register at edge N+2.
  - `vld_out`/`cmen_out`/`data_*` high in the cycle following edge N+2.
- Throughput is one request per cycle with no stall. Back-to-back requests give back-to-back responses.
- `err_out` is registered: it is high for the one cycle after the edge that sampled the offending event.
- The last LOAD write is at edge N and `load_done` at edge N. A SERVE read at edge N+1 must see that written data.
- Writes and reads never overlap, because they occupy different states. There is no forwarding path.
- Asynchronous reset mid-SERVE clears the pipeline immediately. No spurious `vld_out` follows release.

## Structure
- `params` package:
  - `datatype_t` (shared with the address generator).
  - `rsp_state_t` enum {IDLE, LOAD, SERVE}.
  - Constant `RSP_LATENCY = 2`.
- Sub-module `operand_sram`: single-port, synchronous-read, 32-bit × DEPTH. It is instantiated twice (A, B).
- The top level holds the FSM, the range checks, the 2-stage valid/tag pipeline and the formatting logic.

## Test plan
- Load A[0..7] = 0x1000_000i and B[0..7] = 0x2000_000i. Then, with FP32, issue `en_in` with `rdaddr_A`=4 and `rdaddr_B`=6. Expect `vld_out` 2 cycles later with `data_A`=0x1000_0002 and `data_B`=0x2000_0003.
- FP16: A[1]=0xDEAD_BEEF, request `rdaddr_A`=2. Expect `data_A`=0x0000_BEEF.
- INT4: request `rdaddr_A`=4, 8, 12 back-to-back. Expect A[1], A[2], A[3] on three consecutive `vld_out` cycles, with `rsp_cnt` ending at 3.
- With DEPTH=128, request `rdaddr_B`=256. Expect `data_B`=0, `vld_out`=1 and a single `err_out` pulse.
- Assert `en_in` in LOAD, and assert `wr_en` in SERVE. Expect an `err_out` pulse for each, no `vld_out`, and buffer contents unchanged.
- Issue a request at edge N and `abort` at edge N+1. Expect no `vld_out` and state IDLE. Then assert reset in SERVE. Expect all outputs at their reset values asynchronously.
